// File: rtl/thor2021_insn_queue.sv
// -----------------------------------------------------------------------------
// thor2021_insn_queue
//
// Instruction queue between the fetch/align stage and the instruction decoder.
// Fetched 48-bit instructions are stored together with their PCs in a circular
// buffer. An immediate-extension prefix (EXI7/EXI23/EXI41) at the head is fused
// with the instruction that follows it, so the decoder receives both words in
// one transfer: ir_o holds the instruction and xir_o holds the prefix. When two
// prefixes are back to back, the older one has nothing to extend. It is
// discarded and pfx_drop_o pulses.
//
// Ports
//   clk_i, rst_ni    core clock, asynchronous active-low reset
//   flush_i          redirect: discard all queued entries
//   fetch_valid_i    fetch presents fetch_insn_i / fetch_pc_i
//   fetch_ready_o    queue has room (registered occupancy only)
//   fetch_insn_i     instruction word, opcode in [7:0]
//   fetch_pc_i       PC of fetch_insn_i
//   dec_valid_o      ir_o / xir_o / pc_o are valid
//   dec_ready_i      decoder takes the presented instruction
//   ir_o             instruction to decode (never a prefix)
//   xir_o            fused prefix word, or NOP_INSN when there is no prefix
//   pc_o             PC of the prefix when fused, else PC of ir_o
//   count_o          current occupancy, 0..DEPTH
//   pfx_drop_o       one-cycle pulse, in the cycle after a prefix was dropped
//
// DEPTH must be a power of two and at least 4. With at least 4 entries, a
// prefix at the head always leaves room for its successor.
// -----------------------------------------------------------------------------

package thor2021_insn_queue_pkg;

  // Immediate-extension prefix opcodes.
  localparam logic [7:0] OP_EXI7  = 8'h50;
  localparam logic [7:0] OP_EXI23 = 8'h51;
  localparam logic [7:0] OP_EXI41 = 8'h52;
  localparam logic [7:0] OP_NOP   = 8'hF1;

  // Word placed on xir_o when the presented instruction has no prefix.
  localparam logic [47:0] NOP_INSN = {40'd0, OP_NOP};

  function automatic logic is_pfx(input logic [47:0] insn);
    return (insn[7:0] == OP_EXI7) || (insn[7:0] == OP_EXI23) ||
           (insn[7:0] == OP_EXI41);
  endfunction

endpackage

module thor2021_insn_queue
  import thor2021_insn_queue_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 64
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       fetch_valid_i,
  output logic                       fetch_ready_o,
  input  logic [47:0]                fetch_insn_i,
  input  logic [AW-1:0]              fetch_pc_i,
  output logic                       dec_valid_o,
  input  logic                       dec_ready_i,
  output logic [47:0]                ir_o,
  output logic [47:0]                xir_o,
  output logic [AW-1:0]              pc_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       pfx_drop_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [47:0]   insn;
    logic [AW-1:0] pc;
  } entry_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  entry_t        mem [DEPTH];
  logic [PW-1:0] rd_ptr_q;
  logic [PW-1:0] wr_ptr_q;
  logic [CW-1:0] count_q;
  logic          pfx_drop_q;

  // ---------------------------------------------------------------------------
  // Head evaluation (combinational from registered state only)
  // ---------------------------------------------------------------------------
  entry_t head0;
  entry_t head1;
  logic   head0_pfx;
  logic   head1_pfx;
  logic   fused;
  logic   drop_req;

  assign head0     = mem[rd_ptr_q];
  assign head1     = mem[rd_ptr_q + PW'(1)];
  assign head0_pfx = is_pfx(head0.insn);
  assign head1_pfx = is_pfx(head1.insn);

  // NOTE: every output of this block gets a default first, so no path
  // through the if/else tree can leave a value unassigned and infer a latch.
  always_comb begin
    dec_valid_o = 1'b0;
    ir_o        = head0.insn;
    xir_o       = NOP_INSN;
    pc_o        = head0.pc;
    fused       = 1'b0;
    drop_req    = 1'b0;
    if (count_q != '0) begin
      if (!head0_pfx) begin
        dec_valid_o = 1'b1;
      end else if (count_q >= CW'(2)) begin
        // head1 is only meaningful once a second entry exists.
        if (!head1_pfx) begin
          dec_valid_o = 1'b1;
          fused       = 1'b1;
          ir_o        = head1.insn;
          xir_o       = head0.insn;
        end else begin
          // The older prefix is followed by another prefix, so it has no
          // instruction to extend.
          drop_req = 1'b1;
        end
      end
      // A lone prefix at the head waits for its successor.
    end
  end

  // ---------------------------------------------------------------------------
  // Handshakes
  // ---------------------------------------------------------------------------
  logic       enq;
  logic       deq;
  logic       drop;
  logic [1:0] rd_step;

  // Depends on the registered count only, so there is no path from dec_ready_i.
  assign fetch_ready_o = (count_q < CW'(DEPTH));

  // flush_i overrides every other state change in the same cycle.
  assign enq  = fetch_valid_i & fetch_ready_o & ~flush_i;
  assign deq  = dec_valid_o & dec_ready_i & ~flush_i;
  assign drop = drop_req & ~flush_i;

  // A drop needs dec_valid_o=0, so it can never coincide with a dequeue.
  always_comb begin
    rd_step = 2'd0;
    if (deq)       rd_step = fused ? 2'd2 : 2'd1;
    else if (drop) rd_step = 2'd1;
  end

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  // NOTE: the entry array has no reset. An entry is only read after it has
  // been written, and leaving it unreset keeps it a plain RAM.
  always_ff @(posedge clk_i) begin
    if (enq) mem[wr_ptr_q] <= '{insn: fetch_insn_i, pc: fetch_pc_i};
  end

  // ---------------------------------------------------------------------------
  // Pointers, occupancy, drop pulse
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only. Every register
  // then samples pre-edge values, whatever order the blocks are evaluated in.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      pfx_drop_q <= 1'b0;
    end else if (flush_i) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      pfx_drop_q <= 1'b0;
    end else begin
      // Pointers are DEPTH-wide powers of two, so wrap is natural overflow.
      rd_ptr_q   <= rd_ptr_q + PW'(rd_step);
      if (enq) wr_ptr_q <= wr_ptr_q + PW'(1);
      count_q    <= count_q + CW'(enq) - CW'(rd_step);
      pfx_drop_q <= drop;
    end
  end

  assign count_o    = count_q;
  assign pfx_drop_o = pfx_drop_q;

  // ---------------------------------------------------------------------------
  // Design invariants
  // ---------------------------------------------------------------------------
  a_count_bound : assert property (@(posedge clk_i) disable iff (!rst_ni)
    count_q <= CW'(DEPTH));

  a_drop_excl : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(deq && drop));

endmodule

// File: tb/tb_thor2021_insn_queue.sv
// -----------------------------------------------------------------------------
// tb_thor2021_insn_queue
//
// Drives thor2021_insn_queue with directed sequences and then with random
// traffic. Every cycle, the DUT outputs are compared with a queue-based
// reference model. The model works on whole entries: it presents the head,
// fuses a prefix with a following non-prefix, and drops a prefix that is
// followed by another prefix.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_thor2021_insn_queue;
  import thor2021_insn_queue_pkg::*;

  localparam int DEPTH = 8;
  localparam int AW    = 64;

  localparam logic [7:0] OP_ADDIL = 8'h04;
  localparam logic [7:0] OP_ORIL  = 8'h09;

  logic            clk;
  logic            rst_n;
  logic            flush;
  logic            fetch_valid;
  logic            fetch_ready;
  logic [47:0]     fetch_insn;
  logic [AW-1:0]   fetch_pc;
  logic            dec_valid;
  logic            dec_ready;
  logic [47:0]     ir;
  logic [47:0]     xir;
  logic [AW-1:0]   pc;
  logic [$clog2(DEPTH):0] count;
  logic            pfx_drop;

  thor2021_insn_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .flush_i       (flush),
    .fetch_valid_i (fetch_valid),
    .fetch_ready_o (fetch_ready),
    .fetch_insn_i  (fetch_insn),
    .fetch_pc_i    (fetch_pc),
    .dec_valid_o   (dec_valid),
    .dec_ready_i   (dec_ready),
    .ir_o          (ir),
    .xir_o         (xir),
    .pc_o          (pc),
    .count_o       (count),
    .pfx_drop_o    (pfx_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [47:0]   insn;
    logic [AW-1:0] pc;
  } ent_t;

  ent_t mq[$];
  bit   exp_drop_q = 1'b0;

  function automatic bit tb_pfx(input logic [47:0] w);
    return w[7:0] inside {OP_EXI7, OP_EXI23, OP_EXI41};
  endfunction

  function automatic logic [47:0] mk(input logic [7:0] op);
    logic [39:0] hi;
    hi = {8'($urandom), 32'($urandom)};
    return {hi, op};
  endfunction

  // pfx_pct: chance in percent that the word is a prefix.
  function automatic logic [47:0] rnd_insn(input int pfx_pct);
    logic [7:0] op;
    if (int'($urandom_range(99)) < pfx_pct) begin
      case ($urandom_range(2))
        0:       op = OP_EXI7;
        1:       op = OP_EXI23;
        default: op = OP_EXI41;
      endcase
    end else begin
      op = 8'($urandom_range(8'h4F));
    end
    return mk(op);
  endfunction

  // Called at a negedge. Checks the DUT against the model, drives the inputs
  // for one cycle, advances the model at the posedge and returns at the next
  // negedge.
  task automatic step(input logic fv, input logic [47:0] insn,
                      input logic [AW-1:0] ipc, input logic dr,
                      input logic fl);
    bit            e_valid;
    bit            e_fused;
    bit            e_drop;
    logic [47:0]   e_ir;
    logic [47:0]   e_xir;
    logic [AW-1:0] e_pc;
    int            sz;
    ent_t          ne;
    e_valid = 1'b0;
    e_fused = 1'b0;
    e_drop  = 1'b0;
    e_ir    = '0;
    e_xir   = NOP_INSN;
    e_pc    = '0;
    sz      = mq.size();
    if (sz > 0) begin
      if (!tb_pfx(mq[0].insn)) begin
        e_valid = 1'b1;
        e_ir    = mq[0].insn;
        e_pc    = mq[0].pc;
      end else if (sz >= 2) begin
        if (!tb_pfx(mq[1].insn)) begin
          e_valid = 1'b1;
          e_fused = 1'b1;
          e_ir    = mq[1].insn;
          e_xir   = mq[0].insn;
          e_pc    = mq[0].pc;
        end else begin
          e_drop = 1'b1;
        end
      end
    end

    check("count_o", 64'(count), 64'(sz));
    check("fetch_ready_o", 64'(fetch_ready), 64'(sz < DEPTH));
    check("pfx_drop_o", 64'(pfx_drop), 64'(exp_drop_q));
    check("dec_valid_o", 64'(dec_valid), 64'(e_valid));
    if (e_valid) begin
      check("ir_o", 64'(ir), 64'(e_ir));
      check("xir_o", 64'(xir), 64'(e_xir));
      check("pc_o", 64'(pc), 64'(e_pc));
    end

    fetch_valid = fv;
    fetch_insn  = insn;
    fetch_pc    = ipc;
    dec_ready   = dr;
    flush       = fl;
    @(posedge clk);

    if (fl) begin
      mq.delete();
      exp_drop_q = 1'b0;
    end else begin
      exp_drop_q = e_drop;
      if (e_drop) begin
        void'(mq.pop_front());
      end else if (e_valid && dr) begin
        void'(mq.pop_front());
        if (e_fused) void'(mq.pop_front());
      end
      if (fv && sz < DEPTH) begin
        ne.insn = insn;
        ne.pc   = ipc;
        mq.push_back(ne);
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic dr);
    for (int i = 0; i < n; i++) step(1'b0, rnd_insn(0), '0, dr, 1'b0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [AW-1:0] rpc;
    rst_n       = 1'b0;
    flush       = 1'b0;
    fetch_valid = 1'b0;
    fetch_insn  = '0;
    fetch_pc    = '0;
    dec_ready   = 1'b0;

    repeat (2) @(negedge clk);
    check("rst count_o", 64'(count), 64'd0);
    check("rst dec_valid_o", 64'(dec_valid), 64'd0);
    check("rst pfx_drop_o", 64'(pfx_drop), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Three plain instructions stream straight through.
    step(1'b1, mk(8'h01), 64'h100, 1'b1, 1'b0);
    step(1'b1, mk(8'h02), 64'h106, 1'b1, 1'b0);
    step(1'b1, mk(8'h03), 64'h10C, 1'b1, 1'b0);
    idle(3, 1'b1);

    // A prefix waits through a fetch stall, then fuses with ADDIL.
    step(1'b1, {40'h12_3456_789A, OP_EXI23}, 64'h200, 1'b1, 1'b0);
    idle(3, 1'b1);
    step(1'b1, mk(OP_ADDIL), 64'h206, 1'b1, 1'b0);
    idle(3, 1'b1);

    // Back-to-back prefixes: EXI7 is dropped and EXI41 fuses with ORIL.
    step(1'b1, mk(OP_EXI7), 64'h300, 1'b1, 1'b0);
    step(1'b1, mk(OP_EXI41), 64'h306, 1'b1, 1'b0);
    step(1'b1, mk(OP_ORIL), 64'h30C, 1'b1, 1'b0);
    idle(4, 1'b1);

    // Fill to DEPTH, then fetch and dequeue together while full. Pointers wrap.
    for (int i = 0; i < DEPTH; i++)
      step(1'b1, rnd_insn(0), 64'h400 + 64'(6 * i), 1'b0, 1'b0);
    step(1'b1, rnd_insn(0), 64'h4F0, 1'b1, 1'b0);
    step(1'b1, rnd_insn(0), 64'h4F6, 1'b1, 1'b0);
    idle(DEPTH + 2, 1'b1);

    // Flush with five entries queued and a fetch in the same cycle.
    for (int i = 0; i < 5; i++)
      step(1'b1, rnd_insn(0), 64'h500 + 64'(6 * i), 1'b0, 1'b0);
    step(1'b1, rnd_insn(0), 64'h5F0, 1'b1, 1'b1);
    idle(2, 1'b1);

    // Asynchronous reset with four entries queued, asserted between clock edges.
    for (int i = 0; i < 4; i++)
      step(1'b1, rnd_insn(0), 64'h600 + 64'(6 * i), 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("async rst count_o", 64'(count), 64'd0);
    check("async rst dec_valid_o", 64'(dec_valid), 64'd0);
    mq.delete();
    exp_drop_q = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, mk(8'h07), 64'h700, 1'b1, 1'b0);
    idle(2, 1'b1);

    // Random traffic with frequent prefixes.
    rpc = 64'h1000;
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(99) < 70), rnd_insn(35), rpc,
           1'($urandom_range(99) < 65), 1'($urandom_range(99) < 3));
      rpc = rpc + 64'd6;
    end
    idle(DEPTH + 4, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
